seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 12 +
 rtl/seq_divider_addsub.sv | 15 +
 rtl/seq_divider.sv | 114 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;
  localparam int WIDTH     = 64;
  localparam int CNT_W     = 7;
  localparam int LAST_ITER = 63;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_divider_addsub.sv
// Generic adder/subtractor: sel=1 computes a - b as a + ~b + 1, and cout=1 then means no borrow.
module addsub #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W-1:0] b_eff;

  assign b_eff        = sel ? ~b : b;
  assign {cout, sum}  = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sel};
endmodule

// File: rtl/seq_divider.sv
// Unsigned 64-bit restoring divider, one quotient bit per clock, 64 iterations per division.
module seq_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import div_pkg::*;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   qsr_q, qsr_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   remo_q, remo_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   trial;
  logic               carry_hi;
  logic               no_borrow;
  logic               step_ok;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   qsr_step;

  assign shifted  = {rem_q[WIDTH-2:0], qsr_q[WIDTH-1]};
  assign carry_hi = rem_q[WIDTH-1];

  addsub #(.W(WIDTH)) u_trial (
    .a    (shifted),
    .b    (dvs_q),
    .sel  (1'b1),
    .sum  (trial),
    .cout (no_borrow)
  );

  // A set carry_hi means the 65-bit shifted value exceeds any 64-bit divisor.
  assign step_ok  = carry_hi | no_borrow;
  assign rem_step = step_ok ? trial : shifted;
  assign qsr_step = {qsr_q[WIDTH-2:0], step_ok};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    qsr_d   = qsr_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      RUN: begin
        rem_d = rem_step;
        qsr_d = qsr_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAST_ITER)) begin
          state_d = DONE;
          quo_d   = qsr_step;
          remo_d  = rem_step;
          dbz_d   = (dvs_q == '0);
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          dvs_d   = divisor;
          qsr_d   = dividend;
          rem_d   = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      qsr_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      qsr_q   <= qsr_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
endmodule
